alu_muldiv_seq: RTL and testbench
=================================

// Module: alu_muldiv_seq
// PURPOSE
//   Multi-cycle sequencer executing RV32M MUL/MULHU/DIVU/REMU by iterating the shared
//   32-bit ALU (one add/sub per cycle, shift-add multiply, restoring divide).
//   Sits beside the execute-stage ALU; drives its opA/opB/S/M/Cin ports while busy,
//   and parks the ALU on SET_ZERO while idle.
// PARAMETERS
//   XLEN       32   operand width; fixed to ALU width, only 32 is supported
//   CNT_W      6    step counter width; must hold XLEN
// PORTS
//   clk          in   1   single clock, all state updates on rising edge
//   rst          in   1   synchronous, active-high reset
//   in_valid     in   1   operation request
//   in_ready     out  1   high only in IDLE
//   in_op        in   2   00 MUL (low), 01 MULHU, 10 DIVU, 11 REMU
//   in_a         in   32  multiplicand / dividend
//   in_b         in   32  multiplier / divisor
//   kill         in   1   abort in-flight op (pipeline flush)
//   out_valid    out  1   result available
//   out_ready    in   1   consumer accepts result
//   out_data     out  32  result
//   busy         out  1   ALU owned by sequencer (state != IDLE)
//   alu_opA      out  32  ALU operand A
//   alu_opB      out  32  ALU operand B
//   alu_S        out  4   ALU select
//   alu_M        out  1   ALU mode
//   alu_Cin      out  1   ALU carry in
//   alu_DO       in   32  ALU data out
//   alu_C        in   1   ALU carry/borrow out
// BEHAVIOUR
// - Reset: state IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, counter=0,
//   hi/lo/divisor registers 0; ALU driven SET_ZERO.
// - ALU codes: SET_ZERO {S,Cin,M}=0000_1_0; ADD 1001_0_1 (A+B); SUB 0110_1_1 (A-B-1, C=borrow).
// - Handshake: accept when in_valid & in_ready; operands/op latched that edge (cycle T).
//   Result held stable with out_valid=1 until out_valid & out_ready; then IDLE next cycle.
//   in_ready=0 in DONE; no back-to-back accept in the release cycle.
// - States: IDLE -> MSTEP (MUL/MULHU) | DPREP (DIV/REM, b!=0) | DONE (DIV/REM, b==0);
//   DPREP -> DSTEP; MSTEP/DSTEP -> DONE after 32 steps; DONE -> IDLE on out_ready.
// - MSTEP (hi=0, lo=in_b, mc=in_a at accept): ADD opA=hi, opB=lo[0]?mc:0;
//   hi <= {alu_C, alu_DO[31:1]}, lo <= {alu_DO[0], lo[31:1]}. Result MUL=lo, MULHU=hi.
// - DPREP: SUB opA=in_b, opB=0 -> dm1 <= b-1 (so step SUB yields R-D exactly).
// - DSTEP (R=0, Q=in_a): rtop=R[31]; Rs={R[30:0],Q[31]}; SUB opA=Rs, opB=dm1;
//   if rtop | ~alu_C: R<=alu_DO, Q<={Q[30:0],1} else R<=Rs, Q<={Q[30:0],0}.
//   Result DIVU=Q, REMU=R.
// - Divide by zero: no iteration; DIVU=32'hFFFF_FFFF, REMU=in_a.
// - Latency (accept at T, out_valid first high): MUL/MULHU T+33; DIV/REM T+34; div0 T+1.
// - Counter counts 0..31 in step states; DONE entered on step 31; no wrap.
// - out_data registered on DONE entry only; ALU outputs combinational from state.
// - kill: any state -> IDLE next edge, out_valid dropped, result discarded; kill in
//   IDLE with in_valid same cycle: request not accepted (kill wins).
// - rst mid-operation: identical to reset values; in-flight op lost, no output.
// - In IDLE/DONE ALU driven SET_ZERO, busy=0 only in IDLE.
// TESTING
// 1 MUL a=7,b=6 -> out_valid at T+33, out_data=42; MULHU same -> 0.
// 2 MULHU a=b=32'hFFFF_FFFF -> 32'hFFFF_FFFE; MUL -> 32'h0000_0001.
// 3 DIVU a=100,b=7 -> 14 at T+34; REMU -> 2; DIVU a=32'hFFFF_FFFF,b=1 -> 32'hFFFF_FFFF.
// 4 DIVU a=5,b=0 -> 32'hFFFF_FFFF at T+1; REMU a=5,b=0 -> 5; REMU a=3,b=32'h8000_0001 -> 3.
// 5 out_ready low 10 cycles -> out_data/out_valid stable, in_ready=0, no new accept.
// 6 kill at step 10 and rst at step 20 -> IDLE next cycle, out_valid never asserted, busy=0.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle RV32M MUL/MULHU/DIVU/REMU sequencer.
// It uses the shared execute-stage ALU for one add or subtract per cycle.
// Multiply is shift-add over 32 steps. Divide is restoring over 32 steps,
// preceded by one prep cycle that forms divisor-1.
module alu_muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic            busy,
  output logic [XLEN-1:0] alu_opA,
  output logic [XLEN-1:0] alu_opB,
  output logic [3:0]      alu_S,
  output logic            alu_M,
  output logic            alu_Cin,
  input  logic [XLEN-1:0] alu_DO,
  input  logic            alu_C
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MSTEP = 3'd1;
  localparam logic [2:0] S_DPREP = 3'd2;
  localparam logic [2:0] S_DSTEP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] ALU_S_ZERO = 4'b0000;
  localparam logic [3:0] ALU_S_ADD  = 4'b1001;
  localparam logic [3:0] ALU_S_SUB  = 4'b0110;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;       // bit1: divide family, bit0: high half / remainder
  logic [XLEN-1:0]  r_hi;       // product high half, or partial remainder R
  logic [XLEN-1:0]  r_lo;       // multiplier shifting out / product low, or quotient Q
  logic [XLEN-1:0]  r_mc;       // multiplicand, or divisor then divisor-1
  logic [XLEN-1:0]  r_out_data;

  logic            w_last;
  logic            w_rtop;
  logic [XLEN-1:0] w_rs;
  logic            w_dsub;
  logic [XLEN-1:0] w_r_nxt;
  logic [XLEN-1:0] w_q_nxt;
  logic [XLEN-1:0] w_mhi_nxt;
  logic [XLEN-1:0] w_mlo_nxt;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out_data  = r_out_data;

  assign w_last = (r_cnt == CNT_W'(XLEN-1));

  // The divide step shifts R:Q left by one.
  // If the bit shifted out of R is set, the shifted R is at least 2^32 and
  // therefore exceeds any divisor, so the subtract must be taken.
  assign w_rtop  = r_hi[XLEN-1];
  assign w_rs    = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
  assign w_dsub  = w_rtop | ~alu_C;
  assign w_r_nxt = w_dsub ? alu_DO : w_rs;
  assign w_q_nxt = {r_lo[XLEN-2:0], w_dsub};

  // Shift-add: the carry and sum shift right into hi, and the sum LSB enters lo.
  assign w_mhi_nxt = {alu_C, alu_DO[XLEN-1:1]};
  assign w_mlo_nxt = {alu_DO[0], r_lo[XLEN-1:1]};

  // ALU drive depends only on state: the ALU is parked on SET_ZERO unless stepping.
  always_comb begin
    alu_opA = '0;
    alu_opB = '0;
    alu_S   = ALU_S_ZERO;
    alu_Cin = 1'b1;
    alu_M   = 1'b0;
    case (r_state)
      S_MSTEP: begin
        alu_opA = r_hi;
        alu_opB = r_lo[0] ? r_mc : '0;
        alu_S   = ALU_S_ADD;
        alu_Cin = 1'b0;
        alu_M   = 1'b1;
      end
      S_DPREP: begin
        alu_opA = r_mc;            // divisor latched at accept; SUB computes A-0-1
        alu_S   = ALU_S_SUB;
        alu_M   = 1'b1;
      end
      S_DSTEP: begin
        alu_opA = w_rs;            // Rs - (D-1) - 1 = Rs - D
        alu_opB = r_mc;
        alu_S   = ALU_S_SUB;
        alu_M   = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer state, datapath registers, and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mc       <= '0;
      r_out_data <= '0;
    end else if (kill) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= in_op;
            r_cnt <= '0;
            if (!in_op[1]) begin
              r_hi    <= '0;
              r_lo    <= in_b;
              r_mc    <= in_a;
              r_state <= S_MSTEP;
            end else if (in_b == '0) begin
              r_out_data <= in_op[0] ? in_a : '1;
              r_state    <= S_DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= in_a;
              r_mc    <= in_b;
              r_state <= S_DPREP;
            end
          end
        end
        S_MSTEP: begin
          r_hi <= w_mhi_nxt;
          r_lo <= w_mlo_nxt;
          if (w_last) begin
            r_cnt      <= '0;
            r_out_data <= r_op[0] ? w_mhi_nxt : w_mlo_nxt;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DPREP: begin
          r_mc    <= alu_DO;
          r_state <= S_DSTEP;
        end
        S_DSTEP: begin
          r_hi <= w_r_nxt;
          r_lo <= w_q_nxt;
          if (w_last) begin
            r_cnt      <= '0;
            r_out_data <= r_op[0] ? w_r_nxt : w_q_nxt;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq, with a behavioural model of the shared ALU.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [31:0] alu_opA;
  logic [31:0] alu_opB;
  logic [3:0]  alu_S;
  logic        alu_M;
  logic        alu_Cin;
  logic [31:0] alu_DO;
  logic        alu_C;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_S(alu_S), .alu_M(alu_M), .alu_Cin(alu_Cin),
    .alu_DO(alu_DO), .alu_C(alu_C)
  );

  // ALU model: ADD gives A+B with a carry out; SUB gives A-B-1 with C as the borrow;
  // any other code yields 0.
  logic [32:0] m_wide;
  always_comb begin
    m_wide = '0;
    case ({alu_S, alu_Cin, alu_M})
      6'b1001_0_1: m_wide = {1'b0, alu_opA} + {1'b0, alu_opB};
      6'b0110_1_1: m_wide = {1'b0, alu_opA} - {1'b0, alu_opB} - 33'd1;
      default:     m_wide = '0;
    endcase
    alu_DO = m_wide[31:0];
    alu_C  = m_wide[32];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_code();
    return {26'd0, alu_S, alu_Cin, alu_M};
  endfunction

  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'h0;   // operands must already be latched
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start(op, a, b);
    wait_valid(lat);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " data"}, out_data, exp);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    release_out(tag);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
    kill = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst alu code", alu_code(), 32'h02);
    chk("rst alu opA", alu_opA, 32'd0);
    chk("rst alu opB", alu_opB, 32'd0);
    rst = 1'b0;

    run("mul 7*6",     2'b00, 32'd7, 32'd6, 32'd42, 33);
    run("mulhu 7*6",   2'b01, 32'd7, 32'd6, 32'd0, 33);
    run("mulhu ff*ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run("mul ff*ff",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run("divu 100/7",  2'b10, 32'd100, 32'd7, 32'd14, 34);
    run("remu 100/7",  2'b11, 32'd100, 32'd7, 32'd2, 34);
    run("divu ff/1",   2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    run("divu 5/0",    2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("remu 5/0",    2'b11, 32'd5, 32'd0, 32'd5, 1);
    run("remu 3/big",  2'b11, 32'd3, 32'h8000_0001, 32'd3, 34);

    // Back-pressure: the result holds while a competing request waits.
    start(2'b00, 32'd7, 32'd6);
    wait_valid(lat);
    chk("bp latency", 32'(lat), 32'd33);
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd2; in_b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp out_data", out_data, 32'd42);
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_out("bp");
    chk("bp no accept busy", 32'(busy), 32'd0);

    // Kill at multiply step 10.
    start(2'b00, 32'd7, 32'd6);
    repeat (11) @(negedge clk);
    chk("kill step alu code", alu_code(), 32'h25);
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("kill busy", 32'(busy), 32'd0);
    chk("kill in_ready", 32'(in_ready), 32'd1);
    chk("kill alu code", alu_code(), 32'h02);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("kill no out_valid", 32'(seen), 32'd0);

    // A kill in the same cycle as a request blocks the accept.
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd1; in_b = 32'd1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    chk("kill idle busy", 32'(busy), 32'd0);

    // Reset at divide step 20.
    start(2'b10, 32'd100, 32'd7);
    repeat (22) @(negedge clk);
    chk("rst mid busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst mid busy0", 32'(busy), 32'd0);
    chk("rst mid out_data", out_data, 32'd0);
    chk("rst mid in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("rst mid no out_valid", 32'(seen), 32'd0);

    run("divu after rst", 2'b10, 32'd100, 32'd7, 32'd14, 34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
